// File: rtl/frame_capture_ctrl_pkg.sv
// Shared types and constants for the camera frame capture controller.
// States, Avalon register addresses and STATUS bit positions.
package frame_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_LINES  = 2'd1;
    localparam logic [1:0] ADDR_FRAMES = 2'd2;
    localparam logic [1:0] ADDR_CONFIG = 2'd3;

    localparam int STAT_IMG  = 0;
    localparam int STAT_WR   = 1;
    localparam int STAT_BUSY = 2;
    localparam int STAT_ERR  = 3;

    localparam int CMD_ARM   = 0;
    localparam int CMD_CLEAR = 1;

endpackage

// File: rtl/frame_capture_ctrl_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses for one async pin.
// Latency: level 2 clk after the pin edge, pulses 3 clk; no backpressure.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
            rise <= sync & ~prev;
            fall <= ~sync & prev;
        end
    end

    assign level = sync;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Arms on button/CPU, gates SDRAM writes for one whole camera frame, verifies line count.
// Latency: fval pin rise->wr_en 4 clk, fall->img_captured 5 clk; zero-wait Avalon slave.
module frame_capture_ctrl
    import frame_capture_ctrl_pkg::*;
#(
    parameter int EXP_LINES = 480,
    parameter int MAX_RETRY = 3,
    parameter int LINE_W    = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic        cam_fval,
    input  logic        cam_lval,
    output logic        sdram_wr_en,
    output logic        img_captured,
    output logic        waitrequest,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata
);

    localparam int RETRY_W = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
    localparam logic [LINE_W-1:0]  LINE_MAX  = '1;

    logic trig_lvl, trig_rise, trig_fall;
    logic fval_lvl, fval_rise, fval_fall;
    logic lval_lvl, lval_rise, lval_fall;

    sync_edge u_sync_trig (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (trigger),
        .level (trig_lvl),
        .rise  (trig_rise),
        .fall  (trig_fall)
    );

    sync_edge u_sync_fval (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cam_fval),
        .level (fval_lvl),
        .rise  (fval_rise),
        .fall  (fval_fall)
    );

    sync_edge u_sync_lval (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cam_lval),
        .level (lval_lvl),
        .rise  (lval_rise),
        .fall  (lval_fall)
    );

    logic sync_unused;
    assign sync_unused = ^{trig_lvl, trig_fall, lval_lvl, lval_fall, writedata[31:LINE_W]};

    state_t              state, state_n;
    logic [RETRY_W-1:0]  retry, retry_n, retry_inc;
    logic                wait_fall, wait_fall_n;
    logic [LINE_W-1:0]   line_cnt, line_cnt_n, line_inc;
    logic [LINE_W-1:0]   lines_q, lines_n;
    logic [LINE_W-1:0]   cfg_q;
    logic [31:0]         frames_q;
    logic [31:0]         rd_mux;

    logic wr_status, cmd_arm, cmd_clear;

    assign wr_status   = write && (address == ADDR_STATUS);
    assign cmd_clear   = wr_status && writedata[CMD_CLEAR];
    // A CPU ARM and a button edge in the same cycle collapse into one arm.
    assign cmd_arm     = (wr_status && writedata[CMD_ARM]) || trig_rise;
    assign waitrequest = 1'b0;

    always_comb begin
        state_n     = state;
        retry_n     = retry;
        wait_fall_n = wait_fall;
        line_cnt_n  = line_cnt;
        lines_n     = lines_q;
        line_inc    = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + LINE_W'(1);
        retry_inc   = retry + RETRY_W'(1);

        case (state)
            ST_IDLE: begin
                if (cmd_arm && !cmd_clear) begin
                    state_n     = ST_ARMED;
                    retry_n     = '0;
                    wait_fall_n = fval_lvl;
                end
            end
            ST_ARMED: begin
                if (cmd_clear) begin
                    state_n = ST_IDLE;
                end else if (wait_fall) begin
                    // Armed mid-frame: let the partial frame pass before accepting a start.
                    if (fval_fall) begin
                        wait_fall_n = 1'b0;
                    end
                end else if (fval_rise) begin
                    state_n    = ST_CAPTURE;
                    line_cnt_n = '0;
                end
            end
            ST_CAPTURE: begin
                if (cmd_clear) begin
                    state_n = ST_IDLE;
                end else begin
                    if (lval_rise) begin
                        line_cnt_n = line_inc;
                    end
                    if (fval_fall) begin
                        state_n = ST_CHECK;
                        lines_n = line_cnt_n;
                    end
                end
            end
            ST_CHECK: begin
                if (cmd_clear) begin
                    state_n = ST_IDLE;
                end else if (line_cnt == cfg_q) begin
                    state_n = ST_DONE;
                end else begin
                    retry_n = retry_inc;
                    if (retry_inc > RETRY_LIM) begin
                        state_n = ST_ERROR;
                    end else begin
                        state_n     = ST_ARMED;
                        wait_fall_n = fval_lvl;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (cmd_clear) begin
                    state_n = ST_IDLE;
                end else if (cmd_arm) begin
                    state_n     = ST_ARMED;
                    retry_n     = '0;
                    wait_fall_n = fval_lvl;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            retry        <= '0;
            wait_fall    <= 1'b0;
            line_cnt     <= '0;
            lines_q      <= '0;
            sdram_wr_en  <= 1'b0;
            img_captured <= 1'b0;
        end else begin
            state        <= state_n;
            retry        <= retry_n;
            wait_fall    <= wait_fall_n;
            line_cnt     <= line_cnt_n;
            lines_q      <= lines_n;
            // Driven from the next state so the gate toggles on the same edge as the FSM.
            sdram_wr_en  <= (state_n == ST_CAPTURE);
            img_captured <= (state_n == ST_DONE);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[STAT_ERR]  = (state == ST_ERROR);
                rd_mux[STAT_BUSY] = (state == ST_ARMED) || (state == ST_CAPTURE);
                rd_mux[STAT_WR]   = sdram_wr_en;
                rd_mux[STAT_IMG]  = img_captured;
            end
            ADDR_LINES:  rd_mux[LINE_W-1:0] = lines_q;
            ADDR_FRAMES: rd_mux = frames_q;
            default:     rd_mux[LINE_W-1:0] = cfg_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q    <= LINE_W'(EXP_LINES);
            frames_q <= '0;
            readdata <= '0;
        end else begin
            if (fval_rise) begin
                frames_q <= frames_q + 32'd1;
            end
            if (write && (address == ADDR_CONFIG)) begin
                cfg_q <= writedata[LINE_W-1:0];
            end
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomised bench for frame_capture_ctrl with a frame-level reference model.
module tb_frame_capture_ctrl;

    localparam int EXP_LINES = 480;
    localparam int MAX_RETRY = 3;
    localparam int LINE_W    = 12;

    localparam int S_IDLE  = 0;
    localparam int S_ARMED = 1;
    localparam int S_CAP   = 2;
    localparam int S_DONE  = 3;
    localparam int S_ERR   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger = 1'b0;
    logic        cam_fval = 1'b0;
    logic        cam_lval = 1'b0;
    logic        sdram_wr_en;
    logic        img_captured;
    logic        waitrequest;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;

    always #5 clk = ~clk;

    frame_capture_ctrl #(
        .EXP_LINES (EXP_LINES),
        .MAX_RETRY (MAX_RETRY),
        .LINE_W    (LINE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trigger      (trigger),
        .cam_fval     (cam_fval),
        .cam_lval     (cam_lval),
        .sdram_wr_en  (sdram_wr_en),
        .img_captured (img_captured),
        .waitrequest  (waitrequest),
        .address      (address),
        .read         (read),
        .readdata     (readdata),
        .write        (write),
        .writedata    (writedata)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int c;
        bit sig;   // 0: sdram_wr_en, 1: img_captured
        bit v;
    } ev_t;
    ev_t ev[$];
    bit exp_wr = 1'b0;
    bit exp_img = 1'b0;

    // Frame-level model of the controller.
    int          m_st, m_wait, m_retry, m_cfg, m_lines;
    logic [31:0] m_frames;
    bit          m_fval;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sched(input int c, input bit sig, input bit v);
        ev_t e;
        e.c = c; e.sig = sig; e.v = v;
        ev.push_back(e);
    endtask

    task automatic m_reset();
        m_st = S_IDLE; m_wait = 0; m_retry = 0; m_cfg = EXP_LINES;
        m_lines = 0; m_frames = 32'd0; m_fval = 1'b0;
    endtask

    task automatic m_arm(input int at);
        if (m_st == S_IDLE || m_st == S_DONE || m_st == S_ERR) begin
            if (m_st == S_DONE) sched(at, 1'b1, 1'b0);
            m_st = S_ARMED;
            m_wait = m_fval;
            m_retry = 0;
        end
    endtask

    task automatic m_clear(input int at);
        if (m_st == S_DONE) sched(at, 1'b1, 1'b0);
        if (m_st == S_CAP) sched(at, 1'b0, 1'b0);
        m_st = S_IDLE;
    endtask

    task automatic m_rise(input int k);
        m_frames = m_frames + 32'd1;
        m_fval = 1'b1;
        if (m_st == S_ARMED && m_wait == 0) begin
            m_st = S_CAP;
            sched(k + 4, 1'b0, 1'b1);
        end
    endtask

    task automatic m_fall(input int k, input int nl);
        m_fval = 1'b0;
        if (m_st == S_ARMED) begin
            m_wait = 0;
        end else if (m_st == S_CAP) begin
            sched(k + 4, 1'b0, 1'b0);
            m_lines = nl;
            if (nl == m_cfg) begin
                m_st = S_DONE;
                sched(k + 5, 1'b1, 1'b1);
            end else begin
                m_retry++;
                m_st = (m_retry > MAX_RETRY) ? S_ERR : S_ARMED;
                m_wait = 0;
            end
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: begin
                r[3] = (m_st == S_ERR);
                r[2] = (m_st == S_ARMED) || (m_st == S_CAP);
                r[0] = (m_st == S_DONE);
            end
            2'd1: r = 32'(m_lines);
            2'd2: r = m_frames;
            default: r = 32'(m_cfg);
        endcase
        return r;
    endfunction

    // Per-cycle output comparison against the scheduled expectations.
    initial begin
        forever begin
            int i;
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                ev.delete();
                exp_wr = 1'b0;
                exp_img = 1'b0;
            end
            i = 0;
            while (i < ev.size()) begin
                if (ev[i].c <= cyc) begin
                    if (ev[i].sig) exp_img = ev[i].v;
                    else exp_wr = ev[i].v;
                    ev.delete(i);
                end else begin
                    i++;
                end
            end
            if (chk_en && rst_n) begin
                chk("sdram_wr_en", {31'd0, sdram_wr_en}, {31'd0, exp_wr});
                chk("img_captured", {31'd0, img_captured}, {31'd0, exp_img});
                chk("waitrequest", {31'd0, waitrequest}, 32'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        int k;
        k = cyc;
        address = a; writedata = d; write = 1'b1;
        if (a == 2'd0) begin
            if (d[1]) m_clear(k + 1);
            else if (d[0]) m_arm(k + 1);
        end else if (a == 2'd3) begin
            m_cfg = int'(d[LINE_W-1:0]);
        end
        tick(1);
        write = 1'b0;
        tick(2);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string nm);
        address = a; read = 1'b1;
        tick(1);
        read = 1'b0;
        chk(nm, readdata, exp);
        tick(1);
    endtask

    task automatic trig();
        int k;
        k = cyc;
        trigger = 1'b1;
        m_arm(k + 4);
        tick(4);
        trigger = 1'b0;
        tick(6);
    endtask

    // mid: 0 none, 1 trigger, 2 write ARM, 3 write CLEAR, 4 write CONFIG=nl (all mid-frame)
    task automatic frame(input int nl, input int mid, input bit lat);
        int k;
        cam_fval = 1'b1;
        k = cyc;
        m_rise(k);
        tick(3);
        if (lat) chk("lat_wr_rise+3", {31'd0, sdram_wr_en}, 32'd0);
        tick(1);
        if (lat) chk("lat_wr_rise+4", {31'd0, sdram_wr_en}, 32'd1);
        if (mid == 1) trig();
        else if (mid == 2) wr_reg(2'd0, 32'd1);
        else if (mid == 3) wr_reg(2'd0, 32'd2);
        else if (mid == 4) wr_reg(2'd3, 32'(nl));
        for (int i = 0; i < nl; i++) begin
            cam_lval = 1'b1;
            tick($urandom_range(1, 4));
            cam_lval = 1'b0;
            tick($urandom_range(2, 4));
        end
        tick(2);
        cam_fval = 1'b0;
        k = cyc;
        m_fall(k, nl);
        tick(3);
        if (lat) chk("lat_wr_fall+3", {31'd0, sdram_wr_en}, 32'd1);
        tick(1);
        if (lat) chk("lat_wr_fall+4", {31'd0, sdram_wr_en}, 32'd0);
        if (lat) chk("lat_img_fall+4", {31'd0, img_captured}, 32'd0);
        tick(1);
        if (lat) chk("lat_img_fall+5", {31'd0, img_captured}, 32'd1);
        tick(6);
    endtask

    initial begin
        m_reset();
        tick(3);
        chk("rst_wr_en", {31'd0, sdram_wr_en}, 32'd0);
        chk("rst_img", {31'd0, img_captured}, 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        rst_n = 1'b1;
        tick(3);
        chk_en = 1'b1;
        rd_reg(2'd3, 32'd480, "cfg_reset");

        // Basic capture with latency pins.
        wr_reg(2'd3, 32'd4);
        rd_reg(2'd3, 32'd4, "cfg_written");
        wr_reg(2'd0, 32'd1);
        frame(4, 0, 1'b1);
        rd_reg(2'd1, 32'd4, "lines_first");
        rd_reg(2'd0, 32'h1, "status_done");
        rd_reg(2'd2, 32'd1, "frames_first");

        // CLEAR in DONE, next frame ignored.
        wr_reg(2'd0, 32'd2);
        rd_reg(2'd0, 32'h0, "status_cleared");
        frame(4, 0, 1'b0);

        // Arm mid-frame: that frame is skipped, the next is captured.
        frame(4, 2, 1'b0);
        rd_reg(2'd0, 32'h4, "status_wait_next");
        frame(4, 0, 1'b0);
        rd_reg(2'd0, 32'h1, "status_midarm_done");

        // Retry exhaustion.
        wr_reg(2'd0, 32'd1);
        for (int i = 0; i < 3; i++) frame(3, 0, 1'b0);
        rd_reg(2'd0, 32'h4, "status_retrying");
        frame(3, 0, 1'b0);
        rd_reg(2'd0, 32'h8, "status_error");
        rd_reg(2'd1, 32'd3, "lines_short");
        wr_reg(2'd0, 32'd1);
        frame(4, 0, 1'b0);
        rd_reg(2'd0, 32'h1, "status_recovered");

        // ARM+CLEAR together, trigger during capture, CONFIG write during capture.
        wr_reg(2'd0, 32'd1);
        wr_reg(2'd0, 32'd3);
        rd_reg(2'd0, 32'h0, "status_arm_clear");
        trig();
        rd_reg(2'd0, 32'h4, "status_trig_armed");
        frame(4, 1, 1'b0);
        rd_reg(2'd2, 32'd10, "frames_count");
        rd_reg(2'd0, 32'h1, "status_trig_done");
        wr_reg(2'd0, 32'd1);
        frame(5, 4, 1'b0);
        rd_reg(2'd3, 32'd5, "cfg_mid_capture");
        rd_reg(2'd0, 32'h1, "status_cfg_done");

        // Randomised traffic.
        for (int it = 0; it < 150; it++) begin
            int r;
            int nl;
            int lo;
            int mid;
            logic [31:0] d;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                lo = (m_cfg > 1) ? m_cfg - 1 : 1;
                nl = $urandom_range(lo, m_cfg + 1);
                mid = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                frame(nl, mid, 1'b0);
            end else if (r == 4) begin
                d = $urandom;
                d[1:0] = 2'b01;
                wr_reg(2'd0, d);
            end else if (r == 5) begin
                wr_reg(2'd0, 32'd2);
            end else if (r == 6) begin
                wr_reg(2'd0, 32'd3);
            end else if (r == 7) begin
                trig();
            end else if (r == 8) begin
                d = $urandom;
                d[LINE_W-1:0] = LINE_W'($urandom_range(2, 6));
                wr_reg(2'd3, d);
            end else begin
                for (int a = 0; a < 4; a++) rd_reg(2'(a), m_read(2'(a)), "rand_read");
            end
        end

        // Asynchronous reset in the middle of a capture.
        wr_reg(2'd0, 32'd2);
        wr_reg(2'd0, 32'd1);
        cam_fval = 1'b1;
        m_rise(cyc);
        tick(8);
        chk("wr_before_rst", {31'd0, sdram_wr_en}, 32'd1);
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wr", {31'd0, sdram_wr_en}, 32'd0);
        chk("rst_async_img", {31'd0, img_captured}, 32'd0);
        cam_fval = 1'b0;
        tick(3);
        m_reset();
        rst_n = 1'b1;
        tick(5);
        chk_en = 1'b1;
        rd_reg(2'd0, 32'h0, "post_rst_status");
        rd_reg(2'd1, 32'd0, "post_rst_lines");
        rd_reg(2'd2, 32'd0, "post_rst_frames");
        rd_reg(2'd3, 32'd480, "post_rst_cfg");
        tick(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Upstream stage of the HPS pixel transfer path.
- Arms on a push-button or CPU command, waits for a clean camera frame start, and opens the SDRAM write gate for exactly one full frame.
- Checks the line count, then raises img_captured (the pix_rdy input of the pixel-transfer slave) and holds it until the CPU clears it.
- Exposes status, counters and configuration through a small Avalon-MM slave on the same clock.

Parameters:
- EXP_LINES, 480, default expected number of camera lines per frame (reset value of the CONFIG register).
- MAX_RETRY, 3, number of bad frames tolerated before entering ERROR.
- LINE_W, 12, width of the line counter.

Ports:
- clk  in  1  system clock; Avalon slave and all logic run on it.
- rst_n  in  1  reset, asynchronous, active-low.
- trigger  in  1  push-button, active high, asynchronous to clk.
- cam_fval  in  1  camera frame-valid, asynchronous to clk.
- cam_lval  in  1  camera line-valid, asynchronous to clk.
- sdram_wr_en  out  1  gate for the SDRAM write FIFO; changes only in vertical blanking.
- img_captured  out  1  a full, verified frame is in SDRAM.
- waitrequest  out  1  always 0; the slave has zero wait states.
- address  in  2  register select.
- read  in  1  Avalon read strobe.
- readdata  out  32  read data.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.

Behaviour:
- Reset (asynchronous, active-low):
  - sdram_wr_en=0, img_captured=0, readdata=0, waitrequest=0.
  - State IDLE; counters 0; retry=0; CONFIG=EXP_LINES.
  - Asserting rst_n low mid-capture drops sdram_wr_en immediately.
- Synchronisation:
  - trigger, cam_fval and cam_lval each pass through 2 flip-flops, then an edge register.
  - Rise and fall pulses are valid 3 clk after the pin edge.
  - The trigger rise pulse is the arm source; there is no debounce beyond edge detection, and repeated edges while not IDLE/DONE/ERROR are ignored.
- Register map:
  - addr 0 STATUS:
    - Read: {28'b0, state_is_error, busy, sdram_wr_en, img_captured}. busy=1 in ARMED or CAPTURE.
    - Write: bit0 ARM, bit1 CLEAR.
  - addr 1 LINES (read-only): line count of the last completed frame, zero-extended.
  - addr 2 FRAMES (read-only): count of fval rising edges since reset; 32-bit, wraps to 0.
  - addr 3 CONFIG (read/write): bits[LINE_W-1:0] hold the expected line count.
  - readdata is registered: valid the cycle after read is sampled, held otherwise.
  - Unused write bits are ignored.
- State machine:
  - IDLE: on ARM or trigger rise → ARMED; clear img_captured; retry=0.
  - ARMED:
    - If fval_sync is already high at entry, wait for its fall first, so a partial frame is never captured.
    - On the fval rise pulse → CAPTURE; sdram_wr_en=1 next cycle; line_cnt=0.
  - CAPTURE:
    - Each lval rise pulse increments line_cnt, saturating at all-ones.
    - On the fval fall pulse → CHECK; sdram_wr_en=0 next cycle; LINES=line_cnt.
  - CHECK (1 cycle):
    - line_cnt==CONFIG → DONE, img_captured=1.
    - Otherwise retry+1; if retry+1 > MAX_RETRY → ERROR, else → ARMED.
  - DONE: img_captured held at 1. CLEAR → IDLE (img_captured=0). ARM or trigger → ARMED (img_captured=0).
  - ERROR: img_captured=0. CLEAR → IDLE; ARM or trigger → ARMED with retry=0.
- Simultaneous events:
  - ARM and trigger in the same cycle count as one arm.
  - ARM and CLEAR written together: CLEAR wins.
  - CLEAR in ARMED/CAPTURE/CHECK aborts to IDLE; sdram_wr_en=0 next cycle.
  - A CONFIG write during CAPTURE takes effect at the following CHECK.
- Latency: fval rise pin → sdram_wr_en high is 4 clk; fval fall pin → img_captured high is 5 clk.

Decomposition:
- Shared package: state enum (IDLE, ARMED, CAPTURE, CHECK, DONE, ERROR), register address constants, and STATUS bit positions.
- One sub-module, sync_edge: 2FF synchroniser plus rise/fall pulse generator. Instantiated 3 times.

Test Plan:
- Reset, write CONFIG=4, write STATUS=1, then drive a frame with fval high and 4 lval pulses → sdram_wr_en high 4 clk after the fval rise and low 4 clk after the fall; img_captured=1; LINES reads 4; STATUS reads 0x1.
- Arm while fval is already high (mid-frame) → no capture for that frame; capture occurs on the next full frame.
- CONFIG=4, MAX_RETRY=3, four consecutive 3-line frames → STATUS reads 0x8 (ERROR); ARM then one 4-line frame → img_captured=1.
- In DONE, write STATUS=2 → img_captured=0 next cycle, STATUS reads 0x0; a following frame is not captured.
- Write STATUS=3 while in ARMED → ends in IDLE; trigger pulse in CAPTURE → ignored, FRAMES increments once per frame.
- Assert rst_n low mid-CAPTURE → sdram_wr_en drops with no clock edge; after release all registers read their reset values and CONFIG reads EXP_LINES.
